// File: rtl/tx_status_rr_arbiter.sv
// Two-input round-robin arbiter merging MAC TX status and JTAG debug status
// into one registered Avalon-ST source, with saturating debug counters.
module tx_status_rr_arbiter #(
    parameter int DATA_W = 40,
    parameter int ERR_W  = 7,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic [ERR_W-1:0]  in0_error,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic [ERR_W-1:0]  in1_error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ERR_W-1:0]  out_error,
    output logic              out_channel,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  err_cnt
);

    // Handshake: a word moves on any cycle where valid and ready are both high;
    // ready never looks at the same source's valid, only at the other source.
    logic load_en;
    logic last;
    logic acc0;
    logic acc1;
    logic acc_err;

    assign load_en   = ~out_valid | out_ready;
    assign in0_ready = load_en & (~in1_valid | last);
    assign in1_ready = load_en & (~in0_valid | ~last);
    assign acc0      = in0_valid & in0_ready;
    assign acc1      = in1_valid & in1_ready;
    assign acc_err   = (acc0 & (|in0_error)) | (acc1 & (|in1_error));

    // last starts at 1 so source 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_error   <= '0;
            out_channel <= 1'b0;
            last        <= 1'b1;
        end else if (load_en) begin
            out_valid <= acc0 | acc1;
            if (acc0) begin
                out_data    <= in0_data;
                out_error   <= in0_error;
                out_channel <= 1'b0;
                last        <= 1'b0;
            end else if (acc1) begin
                out_data    <= in1_data;
                out_error   <= in1_error;
                out_channel <= 1'b1;
                last        <= 1'b1;
            end
        end
    end

    // Clear beats a coincident increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0    <= '0;
            cnt1    <= '0;
            err_cnt <= '0;
        end else if (clr_cnt) begin
            cnt0    <= '0;
            cnt1    <= '0;
            err_cnt <= '0;
        end else begin
            if (acc0 && (cnt0 != {CNT_W{1'b1}})) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (acc1 && (cnt1 != {CNT_W{1'b1}})) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
            if (acc_err && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_status_rr_arbiter.sv
// Bench for tx_status_rr_arbiter: directed table, hand sequences for stall,
// saturation/clear and async reset, then random traffic against a reference model.
module tb_tx_status_rr_arbiter;

    localparam int DW   = 40;
    localparam int EW   = 7;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1, ordy, clr;
    logic [DW-1:0] d0, d1;
    logic [EW-1:0] e0, e1;
    logic          in0_ready, in1_ready, out_valid, out_channel;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_error;
    logic [CW-1:0] cnt0, cnt1, err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit          m_valid;
    logic [DW-1:0] m_data;
    logic [EW-1:0] m_err;
    bit          m_ch;
    bit          m_last;
    int          m_c0, m_c1, m_ce;

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic [EW-1:0] e0;
        logic          v1;
        logic [DW-1:0] d1;
        logic [EW-1:0] e1;
        logic          ordy;
        logic          clr;
        logic          xv;
        logic [DW-1:0] xd;
        logic [EW-1:0] xe;
        logic          xch;
        logic [CW-1:0] xc0;
        logic [CW-1:0] xc1;
        logic [CW-1:0] xce;
    } vec_t;

    vec_t tbl[15];

    tx_status_rr_arbiter #(.DATA_W(DW), .ERR_W(EW), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst),
        .in0_valid(v0), .in0_ready(in0_ready), .in0_data(d0), .in0_error(e0),
        .in1_valid(v1), .in1_ready(in1_ready), .in1_data(d1), .in1_error(e1),
        .out_valid(out_valid), .out_ready(ordy), .out_data(out_data),
        .out_error(out_error), .out_channel(out_channel),
        .clr_cnt(clr), .cnt0(cnt0), .cnt1(cnt1), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_err = '0; m_ch = 0; m_last = 1;
        m_c0 = 0; m_c1 = 0; m_ce = 0;
    endtask

    // One clock: check readies against the model before the edge, advance the
    // model with the sampled inputs, then check registered outputs after it.
    task automatic cycle();
        bit loadable;
        int g;
        #1;
        loadable = !m_valid || ordy;
        chk("mdl_rdy0", in0_ready, loadable && !(v1 && !m_last));
        chk("mdl_rdy1", in1_ready, loadable && !(v0 && m_last));
        @(posedge clk);
        if (loadable) begin
            g = -1;
            if (v0 && v1) g = m_last ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
            if (g < 0) begin
                m_valid = 0;
            end else begin
                m_valid = 1;
                m_data  = (g == 1) ? d1 : d0;
                m_err   = (g == 1) ? e1 : e0;
                m_ch    = (g == 1);
                m_last  = (g == 1);
                if (g == 0) m_c0 = sat(m_c0);
                else        m_c1 = sat(m_c1);
                if (m_err != 0) m_ce = sat(m_ce);
            end
        end
        if (clr) begin
            m_c0 = 0; m_c1 = 0; m_ce = 0;
        end
        #1;
        chk("mdl_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("mdl_data", out_data, m_data);
            chk("mdl_error", out_error, m_err);
            chk("mdl_chan", out_channel, m_ch);
        end
        chk("mdl_cnt0", cnt0, m_c0);
        chk("mdl_cnt1", cnt1, m_c1);
        chk("mdl_errcnt", err_cnt, m_ce);
    endtask

    task automatic idle();
        v0 = 0; v1 = 0; clr = 0;
    endtask

    initial begin
        logic [63:0] r0, r1;

        tbl[0]  = '{1'b1, 40'h1,   7'h0, 1'b0, 40'h0,   7'h0,  1'b1, 1'b0, 1'b1, 40'h1,   7'h0,  1'b0, 4'd1, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, 40'h2,   7'h0, 1'b0, 40'h0,   7'h0,  1'b1, 1'b0, 1'b1, 40'h2,   7'h0,  1'b0, 4'd2, 4'd0, 4'd0};
        tbl[2]  = '{1'b1, 40'h3,   7'h0, 1'b0, 40'h0,   7'h0,  1'b1, 1'b0, 1'b1, 40'h3,   7'h0,  1'b0, 4'd3, 4'd0, 4'd0};
        tbl[3]  = '{1'b1, 40'h4,   7'h0, 1'b0, 40'h0,   7'h0,  1'b1, 1'b0, 1'b1, 40'h4,   7'h0,  1'b0, 4'd4, 4'd0, 4'd0};
        tbl[4]  = '{1'b0, 40'h0,   7'h0, 1'b0, 40'h0,   7'h0,  1'b1, 1'b0, 1'b0, 40'h4,   7'h0,  1'b0, 4'd4, 4'd0, 4'd0};
        tbl[5]  = '{1'b0, 40'h0,   7'h0, 1'b1, 40'h100, 7'h0,  1'b1, 1'b0, 1'b1, 40'h100, 7'h0,  1'b1, 4'd4, 4'd1, 4'd0};
        tbl[6]  = '{1'b1, 40'hA0,  7'h0, 1'b1, 40'hB0,  7'h0,  1'b1, 1'b0, 1'b1, 40'hA0,  7'h0,  1'b0, 4'd5, 4'd1, 4'd0};
        tbl[7]  = '{1'b1, 40'hA1,  7'h0, 1'b1, 40'hB0,  7'h0,  1'b1, 1'b0, 1'b1, 40'hB0,  7'h0,  1'b1, 4'd5, 4'd2, 4'd0};
        tbl[8]  = '{1'b1, 40'hA1,  7'h0, 1'b1, 40'hB1,  7'h0,  1'b1, 1'b0, 1'b1, 40'hA1,  7'h0,  1'b0, 4'd6, 4'd2, 4'd0};
        tbl[9]  = '{1'b1, 40'hA2,  7'h0, 1'b1, 40'hB1,  7'h0,  1'b1, 1'b0, 1'b1, 40'hB1,  7'h0,  1'b1, 4'd6, 4'd3, 4'd0};
        tbl[10] = '{1'b1, 40'hA2,  7'h0, 1'b1, 40'hB2,  7'h0,  1'b1, 1'b0, 1'b1, 40'hA2,  7'h0,  1'b0, 4'd7, 4'd3, 4'd0};
        tbl[11] = '{1'b1, 40'hA3,  7'h0, 1'b1, 40'hB2,  7'h0,  1'b1, 1'b0, 1'b1, 40'hB2,  7'h0,  1'b1, 4'd7, 4'd4, 4'd0};
        tbl[12] = '{1'b0, 40'h0,   7'h0, 1'b1, 40'hC0,  7'h00, 1'b1, 1'b0, 1'b1, 40'hC0,  7'h00, 1'b1, 4'd7, 4'd5, 4'd0};
        tbl[13] = '{1'b0, 40'h0,   7'h0, 1'b1, 40'hC1,  7'h04, 1'b1, 1'b0, 1'b1, 40'hC1,  7'h04, 1'b1, 4'd7, 4'd6, 4'd1};
        tbl[14] = '{1'b0, 40'h0,   7'h0, 1'b1, 40'hC2,  7'h40, 1'b1, 1'b0, 1'b1, 40'hC2,  7'h40, 1'b1, 4'd7, 4'd7, 4'd2};

        // Reset
        rst = 1; v0 = 0; v1 = 0; d0 = '0; d1 = '0; e0 = '0; e1 = '0; ordy = 1; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 40'h0);
        chk("rst_chan", out_channel, 1'b0);
        chk("rst_cnt0", cnt0, 4'd0);
        chk("rst_errcnt", err_cnt, 4'd0);
        chk("rst_rdy0", in0_ready, 1'b1);
        chk("rst_rdy1", in1_ready, 1'b1);
        rst = 0;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            v0 = tbl[i].v0; d0 = tbl[i].d0; e0 = tbl[i].e0;
            v1 = tbl[i].v1; d1 = tbl[i].d1; e1 = tbl[i].e1;
            ordy = tbl[i].ordy; clr = tbl[i].clr;
            cycle();
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].xv);
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].xd);
            chk($sformatf("tbl%0d_error", i), out_error, tbl[i].xe);
            chk($sformatf("tbl%0d_chan", i), out_channel, tbl[i].xch);
            chk($sformatf("tbl%0d_cnt0", i), cnt0, tbl[i].xc0);
            chk($sformatf("tbl%0d_cnt1", i), cnt1, tbl[i].xc1);
            chk($sformatf("tbl%0d_errcnt", i), err_cnt, tbl[i].xce);
        end

        // Output stall with both sources waiting
        v0 = 1; d0 = 40'hD0; e0 = 0; v1 = 1; d1 = 40'hE0; e1 = 0; ordy = 1; clr = 0;
        cycle();
        chk("stall_load_data", out_data, 40'hD0);
        chk("stall_load_cnt0", cnt0, 4'd8);
        d0 = 40'hD1; ordy = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rdy0", in0_ready, 1'b0);
            chk("stall_rdy1", in1_ready, 1'b0);
            #1;
            cycle();
            chk("stall_hold_data", out_data, 40'hD0);
            chk("stall_hold_valid", out_valid, 1'b1);
            chk("stall_hold_cnt0", cnt0, 4'd8);
            chk("stall_hold_cnt1", cnt1, 4'd7);
        end
        ordy = 1;
        cycle();
        chk("stall_rel_data", out_data, 40'hE0);
        chk("stall_rel_chan", out_channel, 1'b1);
        chk("stall_rel_cnt1", cnt1, 4'd8);
        idle();
        cycle();

        // Saturation and clear
        clr = 1;
        cycle();
        chk("clr_cnt0", cnt0, 4'd0);
        chk("clr_cnt1", cnt1, 4'd0);
        chk("clr_errcnt", err_cnt, 4'd0);
        clr = 0;
        for (int i = 0; i < 17; i++) begin
            v0 = 1; d0 = 40'(i + 'h300); e0 = 0;
            cycle();
            if (i == 14) chk("sat_at15", cnt0, 4'd15);
        end
        chk("sat_after17", cnt0, 4'd15);
        d0 = 40'hF0; clr = 1;
        cycle();
        chk("clracc_cnt0", cnt0, 4'd0);
        chk("clracc_valid", out_valid, 1'b1);
        chk("clracc_data", out_data, 40'hF0);
        idle();
        cycle();

        // Async reset while a word is held under back-pressure
        v0 = 1; d0 = 40'h55; ordy = 1;
        cycle();
        idle(); ordy = 0;
        #2;
        rst = 1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_cnt0", cnt0, 4'd0);
        model_reset();
        v0 = 1; v1 = 1; d0 = 40'h77; d1 = 40'h88;
        #1;
        chk("arst_rdy0", in0_ready, 1'b1);
        chk("arst_rdy1", in1_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("arst_no_accept", out_valid, 1'b0);
        rst = 0; ordy = 1;
        cycle();
        chk("arst_first_chan", out_channel, 1'b0);
        chk("arst_first_data", out_data, 40'h77);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            r0 = {$urandom, $urandom};
            r1 = {$urandom, $urandom};
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            d0 = r0[DW-1:0];
            d1 = r1[DW-1:0];
            e0 = ($urandom_range(0, 3) == 0) ? EW'($urandom) : '0;
            e1 = ($urandom_range(0, 3) == 0) ? EW'($urandom) : '0;
            ordy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
